line_clamp_sequencer: RTL and testbench



---
 rtl/vidcond_pkg.sv | 17 +
 rtl/porch_averager.sv | 42 ++++
 rtl/line_clamp_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_line_clamp_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vidcond_pkg.sv
// Shared line-state type and 24 MHz timing defaults for the composite-video
// conditioning path.
package vidcond_pkg;

  typedef enum logic [2:0] {
    StHunt,
    StSync,
    StBreeze,
    StPorch,
    StActive
  } line_state_e;

  localparam int unsigned SYNC_MIN_24M   = 48;
  localparam int unsigned BREEZE_LEN_24M = 16;
  localparam int unsigned LINE_MAX_24M   = 1800;

endpackage

// File: rtl/porch_averager.sv
// Back-porch black-level averager: sums 2^PORCH_LOG2 samples and presents the
// truncated mean together with the final sample.
module porch_averager
  import vidcond_pkg::*;
#(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned PORCH_LOG2 = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ce,
  input  logic [WIDTH-1:0] sample,
  output logic             done,
  output logic [WIDTH-1:0] avg
);

  localparam int unsigned AccW = WIDTH + PORCH_LOG2;

  logic [AccW-1:0]       acc_q;
  logic [AccW-1:0]       acc_sum;
  logic [PORCH_LOG2-1:0] cnt_q;

  // Wide enough for 2^PORCH_LOG2 full-scale samples, so the sum never wraps.
  assign acc_sum = acc_q + AccW'(sample);
  assign done    = ce && (cnt_q == '1);
  assign avg     = acc_sum[AccW-1:PORCH_LOG2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (ce) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/line_clamp_sequencer.sv
// Per-line timing controller: tracks sync/breezeway/porch/active, measures black
// level from the porch and conditions the output sample stream.
module line_clamp_sequencer
  import vidcond_pkg::*;
#(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned SYNC_MIN   = SYNC_MIN_24M,
  parameter int unsigned BREEZE_LEN = BREEZE_LEN_24M,
  parameter int unsigned PORCH_LOG2 = 5,
  parameter int unsigned LINE_MAX   = LINE_MAX_24M,
  parameter int unsigned LIMIT_SPAN = 24,
  parameter int unsigned BLACK_INIT = 16,
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             sync_in,
  input  logic             mode,
  input  logic [WIDTH-1:0] cvbs,
  output logic [WIDTH-1:0] cvbs_out,
  output logic [WIDTH-1:0] blacklevel,
  output logic             porch,
  output logic             active,
  output logic             locked,
  output logic             error
);

  localparam int unsigned LineW   = $clog2(LINE_MAX + 1);
  localparam int unsigned BreezeW = $clog2(BREEZE_LEN + 1);
  localparam int unsigned GoodW   = $clog2(LOCK_LINES + 1);

  localparam logic [LineW-1:0]   LineMax    = LineW'(LINE_MAX);
  localparam logic [LineW-1:0]   LineLast   = LineW'(LINE_MAX - 1);
  localparam logic [LineW-1:0]   TipMinCnt  = LineW'(SYNC_MIN - 1);
  localparam logic [BreezeW-1:0] BreezeLast = BreezeW'(BREEZE_LEN - 1);
  localparam logic [GoodW-1:0]   GoodMax    = GoodW'(LOCK_LINES);
  localparam logic [WIDTH:0]     LimSpan    = (WIDTH + 1)'(LIMIT_SPAN);
  localparam logic [WIDTH:0]     PixMaxW    = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0]   PixMax     = {WIDTH{1'b1}};

  line_state_e        state_q, state_d;
  logic               sync_q;
  logic [LineW-1:0]   line_cnt_q, line_cnt_d;
  logic [BreezeW-1:0] breeze_cnt_q, breeze_cnt_d;
  logic [GoodW-1:0]   good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0]   blacklevel_q, blacklevel_d;
  logic [WIDTH-1:0]   cvbs_out_q, cvbs_out_d;
  logic               error_q, error_d;

  logic               sync_rise;
  logic               timeout;
  logic               avg_start;
  logic               avg_ce;
  logic               avg_done;
  logic [WIDTH-1:0]   avg;
  logic [WIDTH:0]     lim_sum;
  logic [WIDTH-1:0]   lim_hi;
  logic [WIDTH-1:0]   clamped;

  assign sync_rise = ce && sync_in && !sync_q;
  // Fires on the ce that brings the line count up to LINE_MAX; beats a coincident sync rise.
  assign timeout   = ce && (state_q != StHunt) && (line_cnt_q == LineLast);
  assign avg_ce    = ce && (state_q == StPorch);

  porch_averager #(
    .WIDTH     (WIDTH),
    .PORCH_LOG2(PORCH_LOG2)
  ) u_porch_averager (
    .clk   (clk),
    .reset (reset),
    .start (avg_start),
    .ce    (avg_ce),
    .sample(cvbs),
    .done  (avg_done),
    .avg   (avg)
  );

  always_comb begin
    line_cnt_d = line_cnt_q;
    if (ce) begin
      if (sync_rise) begin
        line_cnt_d = '0;
      end else if (line_cnt_q != LineMax) begin
        line_cnt_d = line_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    breeze_cnt_d = breeze_cnt_q;
    good_cnt_d   = good_cnt_q;
    blacklevel_d = blacklevel_q;
    error_d      = error_q;
    avg_start    = 1'b0;
    if (ce) begin
      error_d = 1'b0;
      if (timeout) begin
        state_d    = StHunt;
        good_cnt_d = '0;
        error_d    = 1'b1;
      end else begin
        unique case (state_q)
          StHunt: begin
            if (sync_rise) state_d = StSync;
          end
          StSync: begin
            // The line count lags the number of tip samples by one.
            if (!sync_in) begin
              if (line_cnt_q >= TipMinCnt) begin
                state_d      = StBreeze;
                breeze_cnt_d = '0;
                avg_start    = 1'b1;
              end else begin
                state_d = StHunt;
              end
            end
          end
          StBreeze: begin
            if (sync_rise) begin
              state_d    = StSync;
              good_cnt_d = '0;
              error_d    = 1'b1;
            end else if (breeze_cnt_q == BreezeLast) begin
              state_d = StPorch;
            end else begin
              breeze_cnt_d = breeze_cnt_q + 1'b1;
            end
          end
          StPorch: begin
            if (avg_done) begin
              blacklevel_d = avg;
              state_d      = sync_rise ? StSync : StActive;
            end else if (sync_rise) begin
              state_d    = StSync;
              good_cnt_d = '0;
              error_d    = 1'b1;
            end
          end
          StActive: begin
            if (sync_rise) begin
              state_d = StSync;
              if (good_cnt_q != GoodMax) good_cnt_d = good_cnt_q + 1'b1;
            end
          end
          default: state_d = StHunt;
        endcase
      end
    end
  end

  // Upper clamp limit saturates at full scale instead of wrapping.
  always_comb begin
    lim_sum = {1'b0, blacklevel_q} + LimSpan;
    lim_hi  = (lim_sum > PixMaxW) ? PixMax : lim_sum[WIDTH-1:0];
    if (cvbs < blacklevel_q) begin
      clamped = blacklevel_q;
    end else if (cvbs > lim_hi) begin
      clamped = lim_hi;
    end else begin
      clamped = cvbs;
    end
  end

  always_comb begin
    cvbs_out_d = cvbs_out_q;
    if (ce) begin
      cvbs_out_d = cvbs;
      if (mode) begin
        unique case (state_q)
          StHunt:            cvbs_out_d = cvbs;
          StSync:            cvbs_out_d = '0;
          StBreeze, StPorch: cvbs_out_d = blacklevel_q;
          StActive:          cvbs_out_d = clamped;
          default:           cvbs_out_d = cvbs;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StHunt;
      sync_q       <= 1'b0;
      line_cnt_q   <= '0;
      breeze_cnt_q <= '0;
      good_cnt_q   <= '0;
      blacklevel_q <= WIDTH'(BLACK_INIT);
      cvbs_out_q   <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (ce) sync_q <= sync_in;
      line_cnt_q   <= line_cnt_d;
      breeze_cnt_q <= breeze_cnt_d;
      good_cnt_q   <= good_cnt_d;
      blacklevel_q <= blacklevel_d;
      cvbs_out_q   <= cvbs_out_d;
      error_q      <= error_d;
    end
  end

  assign cvbs_out   = cvbs_out_q;
  assign blacklevel = blacklevel_q;
  assign porch      = (state_q == StBreeze) || (state_q == StPorch);
  assign active     = (state_q == StActive);
  assign locked     = (good_cnt_q == GoodMax);
  assign error      = error_q;

endmodule

// File: tb/tb_line_clamp_sequencer.sv
// Scoreboard bench for line_clamp_sequencer: a line-level reference model
// predicts every output, a monitor compares after each clock edge.
module tb_line_clamp_sequencer;

  localparam int SYNC_MIN   = 48;
  localparam int BREEZE_LEN = 16;
  localparam int PORCH_N    = 32;
  localparam int LINE_MAX   = 1800;
  localparam int SPAN       = 24;
  localparam int BLACK_INIT = 16;
  localparam int LOCK       = 4;

  localparam int PH_HUNT   = 0;
  localparam int PH_SYNC   = 1;
  localparam int PH_BREEZE = 2;
  localparam int PH_PORCH  = 3;
  localparam int PH_ACTIVE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       sync_in;
  logic       mode;
  logic [5:0] cvbs;
  logic [5:0] cvbs_out;
  logic [5:0] blacklevel;
  logic       porch;
  logic       active;
  logic       locked;
  logic       error;

  always #5 clk = ~clk;

  line_clamp_sequencer u_dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .sync_in   (sync_in),
    .mode      (mode),
    .cvbs      (cvbs),
    .cvbs_out  (cvbs_out),
    .blacklevel(blacklevel),
    .porch     (porch),
    .active    (active),
    .locked    (locked),
    .error     (error)
  );

  typedef struct {
    int out;
    int bl;
    int porch;
    int active;
    int locked;
    int err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   ce_div = 1;

  // Reference model: line phase, samples since last sync rise, tip length,
  // collected porch samples and completed-line count.
  int m_phase, m_prev_sync, m_since, m_tip, m_bz, m_good, m_bl, m_out, m_err;
  int m_porch[$];

  task automatic chk(input string name, input logic [31:0] act, input int expv);
    n_vec++;
    if (act !== 32'(expv)) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_HUNT; m_prev_sync = 0; m_since = 0; m_tip = 0; m_bz = 0;
    m_good = 0; m_bl = BLACK_INIT; m_out = 0; m_err = 0;
    m_porch.delete();
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    e.out    = m_out;
    e.bl     = m_bl;
    e.porch  = (m_phase == PH_BREEZE || m_phase == PH_PORCH) ? 1 : 0;
    e.active = (m_phase == PH_ACTIVE) ? 1 : 0;
    e.locked = (m_good == LOCK) ? 1 : 0;
    e.err    = m_err;
    return e;
  endfunction

  task automatic model_step(input int s, input int cv, input int m);
    int rise, tmo, hi, sum;
    rise = (s == 1 && m_prev_sync == 0) ? 1 : 0;
    tmo  = (m_phase != PH_HUNT && m_since == LINE_MAX - 1) ? 1 : 0;
    hi   = (m_bl + SPAN > 63) ? 63 : m_bl + SPAN;
    if (m == 0 || m_phase == PH_HUNT) m_out = cv;
    else if (m_phase == PH_SYNC) m_out = 0;
    else if (m_phase == PH_ACTIVE) m_out = (cv < m_bl) ? m_bl : ((cv > hi) ? hi : cv);
    else m_out = m_bl;
    m_err = 0;
    if (tmo == 1) begin
      m_phase = PH_HUNT; m_err = 1; m_good = 0;
    end else begin
      case (m_phase)
        PH_HUNT: if (rise == 1) begin m_phase = PH_SYNC; m_tip = 1; end
        PH_SYNC: begin
          if (s == 1) m_tip++;
          else if (m_tip >= SYNC_MIN) begin m_phase = PH_BREEZE; m_bz = 0; m_porch.delete(); end
          else m_phase = PH_HUNT;
        end
        PH_BREEZE: begin
          if (rise == 1) begin m_phase = PH_SYNC; m_tip = 1; m_err = 1; m_good = 0; end
          else begin m_bz++; if (m_bz == BREEZE_LEN) m_phase = PH_PORCH; end
        end
        PH_PORCH: begin
          m_porch.push_back(cv);
          if (m_porch.size() == PORCH_N) begin
            sum = 0;
            foreach (m_porch[j]) sum += m_porch[j];
            m_bl = sum / PORCH_N;
            m_phase = (rise == 1) ? PH_SYNC : PH_ACTIVE;
            m_tip = 1;
          end else if (rise == 1) begin
            m_phase = PH_SYNC; m_tip = 1; m_err = 1; m_good = 0;
          end
        end
        PH_ACTIVE: begin
          if (rise == 1) begin
            m_phase = PH_SYNC; m_tip = 1;
            if (m_good < LOCK) m_good++;
          end
        end
        default: ;
      endcase
    end
    m_since = (rise == 1) ? 0 : ((m_since < LINE_MAX) ? m_since + 1 : LINE_MAX);
    m_prev_sync = s;
  endtask

  // One sample; with ce_div=2 an idle clock carrying junk inputs precedes it.
  task automatic drive(input int s, input int cv, input int m);
    if (ce_div == 2) begin
      @(negedge clk);
      ce = 1'b0; sync_in = 1'($urandom); cvbs = 6'($urandom); mode = 1'($urandom);
      sb_q.push_back(cur_exp());
    end
    @(negedge clk);
    ce = 1'b1; sync_in = 1'(s); cvbs = 6'(cv); mode = 1'(m);
    model_step(s, cv, m);
    sb_q.push_back(cur_exp());
  endtask

  // kind: 0 = ramp, 1 = random, 2 = full scale during active video.
  task automatic run_line(input int tip, input int period, input int porch_v, input int m,
                          input int kind, input int glitch_at);
    for (int i = 0; i < period; i++) begin
      int s, cv;
      s = (i < tip || (glitch_at > 0 && i >= glitch_at && i < glitch_at + 10)) ? 1 : 0;
      if (i < tip) cv = int'($urandom_range(0, 3));
      else if (i < tip + 60) cv = porch_v;
      else if (kind == 0) cv = (i - tip - 60) % 64;
      else if (kind == 1) cv = int'($urandom_range(0, 63));
      else cv = 63;
      drive(s, cv, m);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_cvbs_out", 32'(cvbs_out), 0);
    chk("rst_blacklevel", 32'(blacklevel), BLACK_INIT);
    chk("rst_porch", 32'(porch), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_error", 32'(error), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("cvbs_out", 32'(cvbs_out), mon_e.out);
      chk("blacklevel", 32'(blacklevel), mon_e.bl);
      chk("porch", 32'(porch), mon_e.porch);
      chk("active", 32'(active), mon_e.active);
      chk("locked", 32'(locked), mon_e.locked);
      chk("error", 32'(error), mon_e.err);
    end
  end

  initial begin
    int tips[5];
    tips = '{10, 47, 48, 112, 112};
    reset = 1'b1; ce = 1'b0; sync_in = 1'b0; mode = 1'b0; cvbs = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk_reset_values();
    @(negedge clk);
    reset = 1'b0;

    // Nominal lines: black level settles at 20, lock after LOCK completed lines.
    repeat (6) run_line(112, 1536, 20, 1, 0, 0);
    @(posedge clk); #2;
    chk("bl_after_lines", 32'(blacklevel), 20);
    chk("locked_after_lines", 32'(locked), 1);

    // High black level: clamp limit must saturate at 63.
    run_line(112, 1536, 50, 1, 1, 0);
    run_line(112, 1536, 50, 1, 2, 0);
    @(posedge clk); #2;
    chk("sat_cvbs_out", 32'(cvbs_out), 63);

    // Short glitch in active video, then a porch abort five samples in.
    run_line(112, 1536, 20, 1, 1, 800);
    run_line(112, 1536, 20, 1, 0, 0);
    run_line(112, 112 + BREEZE_LEN + 1 + 5, 40, 1, 0, 0);
    repeat (2) run_line(112, 1536, 20, 0, 1, 0);

    // Sync disappears: timeout.
    for (int i = 0; i < 2000; i++) drive(0, int'($urandom_range(0, 63)), 1);
    @(posedge clk); #2;
    chk("tmo_locked", 32'(locked), 0);
    chk("tmo_active", 32'(active), 0);
    chk("tmo_porch", 32'(porch), 0);

    // Random tips (glitch and SYNC_MIN boundary), periods (some beyond LINE_MAX), modes.
    repeat (8) begin
      run_line(tips[$urandom_range(0, 4)], int'($urandom_range(700, 1900)),
               int'($urandom_range(0, 63)), int'($urandom_range(0, 1)), 1, 0);
    end

    // Half-rate sample enable.
    ce_div = 2;
    repeat (4) run_line(112, 1536, 20, 1, 0, 0);
    run_line(112, 112 + BREEZE_LEN + 1 + 5, 40, 1, 0, 0);
    run_line(112, 1536, 20, 1, 1, 0);
    ce_div = 1;

    // Asynchronous reset in the middle of active video.
    run_line(112, 1536, 30, 1, 1, 0);
    run_line(112, 800, 30, 1, 1, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_reset_values();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) run_line(112, 1536, 25, 1, 1, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
